// File: rtl/fpu_uart_cmd_bridge.sv
// fpu_uart_cmd_bridge: UART command front-end for the FPU core.
// Receives 8N1 bytes at a programmable clocks-per-bit divisor and assembles
// opcode + operand A (+ operand B unless opcode[7] is set), LSB-first bytes.
// It then issues one FPU request and captures the result and flags.
// Optional feature macro: FPU_UART_TX_EN. When defined, the result bytes and
// then {3'b000, flags} are sent back on tx_o. When undefined, tx_o is tied high.
// Handshake: fpu_valid_o is held with op/a/b stable until the first cycle
// fpu_ready_i is high. That cycle is the transfer, and valid drops on the next.
module fpu_uart_cmd_bridge #(
  parameter int FLEN        = 16,
  parameter int CPB_W       = 16,
  parameter int DEFAULT_CPB = 348
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_i,
  input  logic [CPB_W-1:0] cpb_i,
  input  logic             cpb_load_i,
  output logic             fpu_valid_o,
  input  logic             fpu_ready_i,
  output logic [7:0]       fpu_op_o,
  output logic [FLEN-1:0]  fpu_a_o,
  output logic [FLEN-1:0]  fpu_b_o,
  input  logic             fpu_res_valid_i,
  input  logic [FLEN-1:0]  fpu_res_i,
  input  logic [4:0]       fpu_flags_i,
  output logic [FLEN-1:0]  result_o,
  output logic [4:0]       flags_o,
  output logic             result_valid_o,
  output logic             busy_o,
  output logic [1:0]       err_o,
  output logic             tx_o
);
  localparam int NBYTES = FLEN / 8;

`ifdef FPU_UART_TX_EN
  typedef enum logic [2:0] {S_IDLE, S_OPA, S_OPB, S_ISSUE, S_WAIT, S_TX} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_OPA, S_OPB, S_ISSUE, S_WAIT} state_t;
`endif
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  state_t           state, state_next;
  rx_state_t        rx_state, rx_next;
  logic [CPB_W-1:0] cpb, rx_cnt;
  logic             rx_s1, rx_s2, rx_prev;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             byte_stb, frame_err;
  logic [2:0]       byte_cnt;
  logic             last_byte, rx_tick, rx_half, tx_idle, tx_done;

  assign rx_tick     = (rx_cnt == cpb - 1'b1);
  assign rx_half     = (rx_cnt == (cpb >> 1));
  assign last_byte   = (byte_cnt == 3'(NBYTES - 1));
  assign fpu_valid_o = (state == S_ISSUE);
  assign busy_o      = (state != S_IDLE);

  // Two-flop synchroniser plus previous-sample flop for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_i;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Divisor register: loads only while both serial engines are idle, clamped to >= 4
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cpb <= CPB_W'(DEFAULT_CPB);
    else if (cpb_load_i && rx_state == RX_IDLE && tx_idle)
      cpb <= (cpb_i < CPB_W'(4)) ? CPB_W'(4) : cpb_i;
  end

  // Receiver state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  // Receiver next state: start re-check at half bit, 8 data bits, stop bit
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_s2) rx_next = RX_START;
      RX_START: if (rx_half) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Receiver datapath: bit timing, LSB-first shift, byte strobe and framing error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
      case (rx_state)
        RX_START: begin
          rx_cnt <= rx_half ? '0 : rx_cnt + 1'b1;
          rx_bit <= '0;
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        RX_STOP: begin
          if (rx_tick) begin
            rx_cnt <= '0;
            if (rx_s2) byte_stb  <= 1'b1;
            else       frame_err <= 1'b1;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        default: rx_cnt <= '0;
      endcase
    end
  end

  // Command FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Command FSM next state; a framing error abandons a partially received frame
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (byte_stb) state_next = S_OPA;
      S_OPA: begin
        if (frame_err) state_next = S_IDLE;
        else if (byte_stb && last_byte) state_next = fpu_op_o[7] ? S_ISSUE : S_OPB;
      end
      S_OPB: begin
        if (frame_err) state_next = S_IDLE;
        else if (byte_stb && last_byte) state_next = S_ISSUE;
      end
      S_ISSUE: if (fpu_ready_i) state_next = S_WAIT;
`ifdef FPU_UART_TX_EN
      S_WAIT:  if (fpu_res_valid_i) state_next = S_TX;
      S_TX:    if (tx_done) state_next = S_IDLE;
`else
      S_WAIT:  if (fpu_res_valid_i) state_next = S_IDLE;
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Frame assembly, result capture and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpu_op_o       <= '0;
      fpu_a_o        <= '0;
      fpu_b_o        <= '0;
      byte_cnt       <= '0;
      result_o       <= '0;
      flags_o        <= '0;
      result_valid_o <= 1'b0;
      err_o          <= '0;
    end else begin
      result_valid_o <= 1'b0;
      if (frame_err) begin
        err_o[0] <= 1'b1;
        byte_cnt <= '0;
      end
      if (byte_stb && (state == S_IDLE)) begin
        fpu_op_o <= rx_shift;
        fpu_a_o  <= '0;
        fpu_b_o  <= '0;
        byte_cnt <= '0;
      end
      if (byte_stb && (state == S_OPA)) begin
        fpu_a_o  <= {rx_shift, fpu_a_o[FLEN-1:8]};
        byte_cnt <= last_byte ? 3'd0 : byte_cnt + 1'b1;
      end
      if (byte_stb && (state == S_OPB)) begin
        fpu_b_o  <= {rx_shift, fpu_b_o[FLEN-1:8]};
        byte_cnt <= last_byte ? 3'd0 : byte_cnt + 1'b1;
      end
      if (byte_stb && (state != S_IDLE) && (state != S_OPA) && (state != S_OPB))
        err_o[1] <= 1'b1;
      if ((state == S_WAIT) && fpu_res_valid_i) begin
        result_o       <= fpu_res_i;
        flags_o        <= fpu_flags_i;
        result_valid_o <= 1'b1;
      end
    end
  end

`ifdef FPU_UART_TX_EN
  logic             tx_reg, tx_active;
  logic [9:0]       tx_frame;
  logic [3:0]       tx_bits;
  logic [CPB_W-1:0] tx_cnt;
  logic [2:0]       tx_idx;
  logic [7:0]       tx_data;
  logic             tx_tick;

  assign tx_o    = tx_reg;
  assign tx_idle = (state != S_TX);
  assign tx_tick = (tx_cnt == cpb - 1'b1);
  assign tx_done = tx_active && tx_tick && (tx_bits == 4'd9) && (tx_idx == 3'(NBYTES));

  // Byte to send: result bytes LSB first, then the flags byte
  always_comb begin
    tx_data = {3'b000, flags_o};
    for (int i = 0; i < NBYTES; i++)
      if (tx_idx == 3'(i)) tx_data = result_o[i*8 +: 8];
  end

  // Transmitter: 8N1 frames back to back while in TX, line high otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_reg    <= 1'b1;
      tx_active <= 1'b0;
      tx_frame  <= '1;
      tx_bits   <= '0;
      tx_cnt    <= '0;
      tx_idx    <= '0;
    end else if (state != S_TX) begin
      tx_reg    <= 1'b1;
      tx_active <= 1'b0;
      tx_cnt    <= '0;
      tx_idx    <= '0;
    end else if (!tx_active) begin
      tx_frame  <= {1'b1, tx_data, 1'b0};
      tx_reg    <= 1'b0;
      tx_active <= 1'b1;
      tx_bits   <= '0;
      tx_cnt    <= '0;
    end else if (tx_tick) begin
      tx_cnt <= '0;
      if (tx_bits == 4'd9) begin
        tx_active <= 1'b0;
        tx_idx    <= tx_idx + 1'b1;
        tx_reg    <= 1'b1;
      end else begin
        tx_bits <= tx_bits + 1'b1;
        tx_reg  <= tx_frame[tx_bits + 4'd1];
      end
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
    end
  end
`else
  assign tx_o    = 1'b1;
  assign tx_idle = 1'b1;
  assign tx_done = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_uart_cmd_bridge.sv
// Bench for fpu_uart_cmd_bridge (FLEN=16, CPB=8): directed frames, with a
// scoreboard of expected issues/results checked by an independent monitor.
module tb_fpu_uart_cmd_bridge;
  localparam int FLEN  = 16;
  localparam int CPB_W = 16;
  localparam int CPB   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             rx_i;
  logic [CPB_W-1:0] cpb_i;
  logic             cpb_load_i;
  logic             fpu_valid_o;
  logic             fpu_ready_i;
  logic [7:0]       fpu_op_o;
  logic [FLEN-1:0]  fpu_a_o, fpu_b_o;
  logic             fpu_res_valid_i;
  logic [FLEN-1:0]  fpu_res_i;
  logic [4:0]       fpu_flags_i;
  logic [FLEN-1:0]  result_o;
  logic [4:0]       flags_o;
  logic             result_valid_o, busy_o, tx_o;
  logic [1:0]       err_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8+2*FLEN-1:0] exp_iss_q[$];
  logic [FLEN+4:0]     exp_res_q[$];
  logic                prev_rv = 1'b0;

  fpu_uart_cmd_bridge #(.FLEN(FLEN), .CPB_W(CPB_W), .DEFAULT_CPB(348)) dut (
    .clk(clk), .rst(rst), .rx_i(rx_i), .cpb_i(cpb_i), .cpb_load_i(cpb_load_i),
    .fpu_valid_o(fpu_valid_o), .fpu_ready_i(fpu_ready_i), .fpu_op_o(fpu_op_o),
    .fpu_a_o(fpu_a_o), .fpu_b_o(fpu_b_o), .fpu_res_valid_i(fpu_res_valid_i),
    .fpu_res_i(fpu_res_i), .fpu_flags_i(fpu_flags_i), .result_o(result_o),
    .flags_o(flags_o), .result_valid_o(result_valid_o), .busy_o(busy_o),
    .err_o(err_o), .tx_o(tx_o)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_i = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) tick();
    end
    rx_i = stop;
    repeat (CPB) tick();
    rx_i = 1'b1;
    repeat (4) tick();
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [FLEN-1:0] a, input logic [FLEN-1:0] b);
    send_byte(op, 1'b1);
    for (int i = 0; i < FLEN/8; i++) send_byte(a[i*8 +: 8], 1'b1);
    if (!op[7])
      for (int i = 0; i < FLEN/8; i++) send_byte(b[i*8 +: 8], 1'b1);
  endtask

  task automatic load_cpb(input logic [CPB_W-1:0] v);
    cpb_i = v;
    cpb_load_i = 1'b1;
    tick();
    cpb_load_i = 1'b0;
  endtask

  task automatic fpu_accept(input int hold);
    int t = 0;
    while (!fpu_valid_o && t < 200) begin
      tick();
      t++;
    end
    check("issue_seen", 64'(fpu_valid_o), 64'(1));
    repeat (hold) tick();
    fpu_ready_i = 1'b1;
    tick();
    fpu_ready_i = 1'b0;
  endtask

  task automatic fpu_respond(input logic [FLEN-1:0] res, input logic [4:0] fl);
    repeat (3) tick();
    fpu_res_i = res;
    fpu_flags_i = fl;
    fpu_res_valid_i = 1'b1;
    tick();
    fpu_res_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy_o && t < 2000) begin
      tick();
      t++;
    end
    check(name, 64'(busy_o), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},  64'(fpu_valid_o),    64'(0));
    check({tag, "_busy"},   64'(busy_o),         64'(0));
    check({tag, "_err"},    64'(err_o),          64'(0));
    check({tag, "_tx"},     64'(tx_o),           64'(1));
    check({tag, "_result"}, 64'(result_o),       64'(0));
    check({tag, "_flags"},  64'(flags_o),        64'(0));
    check({tag, "_rv"},     64'(result_valid_o), 64'(0));
    check({tag, "_op"},     64'(fpu_op_o),       64'(0));
  endtask

`ifdef FPU_UART_TX_EN
  task automatic uart_rx_byte(input logic [7:0] exp, input string name);
    int t = 0;
    logic [7:0] got;
    while (tx_o && t < 400) begin
      tick();
      t++;
    end
    check({name, "_start"}, 64'(tx_o), 64'(0));
    repeat (CPB/2) tick();
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) tick();
      got[i] = tx_o;
    end
    check(name, 64'(got), 64'(exp));
    repeat (CPB) tick();
    check({name, "_stop"}, 64'(tx_o), 64'(1));
  endtask
`endif

  // Monitor: compares presented requests and captured results against the queues
  always @(negedge clk) begin
    if (!rst) begin
      if (fpu_valid_o) begin
        if (exp_iss_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_issue: got op=%0h a=%0h b=%0h expected none", fpu_op_o, fpu_a_o, fpu_b_o);
        end else begin
          check("issue_op_a_b", 64'({fpu_op_o, fpu_a_o, fpu_b_o}), 64'(exp_iss_q[0]));
          if (fpu_ready_i) void'(exp_iss_q.pop_front());
        end
      end
      if (result_valid_o) begin
        check("rv_single_cycle", 64'(prev_rv), 64'(0));
        if (exp_res_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got %0h expected none", result_o);
        end else begin
          check("result_flags", 64'({result_o, flags_o}), 64'(exp_res_q.pop_front()));
        end
      end
      prev_rv = result_valid_o;
    end
  end

  // Stimulus
  initial begin
    rst = 1'b1;
    rx_i = 1'b1;
    cpb_i = '0;
    cpb_load_i = 1'b0;
    fpu_ready_i = 1'b0;
    fpu_res_valid_i = 1'b0;
    fpu_res_i = '0;
    fpu_flags_i = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    load_cpb(16'd8);

    // Binary op with ready held low for 3 cycles
    exp_iss_q.push_back({8'h01, 16'h3C00, 16'h4000});
    send_frame(8'h01, 16'h3C00, 16'h4000);
    fpu_accept(3);
    exp_res_q.push_back({16'h4200, 5'h00});
    fpu_respond(16'h4200, 5'h00);
    wait_idle("t1_idle");

    // Unary op: B omitted, forced to zero
    exp_iss_q.push_back({8'h85, 16'h3C00, 16'h0000});
    send_frame(8'h85, 16'h3C00, 16'h0000);
    fpu_accept(0);
    exp_res_q.push_back({16'hBC00, 5'h01});
    fpu_respond(16'hBC00, 5'h01);
    wait_idle("t2_idle");

    // Framing error mid-frame aborts, then a good frame
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h3C, 1'b0);
    repeat (4) tick();
    check("t3_err", 64'(err_o), 64'(2'b01));
    check("t3_busy", 64'(busy_o), 64'(0));
    check("t3_valid", 64'(fpu_valid_o), 64'(0));
    exp_iss_q.push_back({8'h02, 16'h3C00, 16'h4000});
    send_frame(8'h02, 16'h3C00, 16'h4000);
    fpu_accept(1);
    exp_res_q.push_back({16'h3E00, 5'h00});
    fpu_respond(16'h3E00, 5'h00);
    wait_idle("t3_idle");

    // Byte arriving while waiting for the result is an overrun
    exp_iss_q.push_back({8'h03, 16'h2211, 16'h4433});
    send_frame(8'h03, 16'h2211, 16'h4433);
    fpu_accept(0);
    send_byte(8'h55, 1'b1);
    check("t4_err", 64'(err_o), 64'(2'b11));
    check("t4_busy_wait", 64'(busy_o), 64'(1));
    exp_res_q.push_back({16'h1234, 5'h1F});
    fpu_respond(16'h1234, 5'h1F);
    wait_idle("t4_idle");

    // Asynchronous reset during OPA, part way through a byte
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    check("t5_busy_opa", 64'(busy_o), 64'(1));
    rx_i = 1'b0;
    repeat (20) tick();
    #2 rst = 1'b1;
    #1 check_reset_outputs("t5_opa_rst");
    rx_i = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    load_cpb(16'd8);

    // Asynchronous reset during ISSUE
    exp_iss_q.push_back({8'h07, 16'h1111, 16'h2222});
    send_frame(8'h07, 16'h1111, 16'h2222);
    check("t5_issue_up", 64'(fpu_valid_o), 64'(1));
    #2 rst = 1'b1;
    #1 check_reset_outputs("t5_issue_rst");
    if (exp_iss_q.size() != 0) void'(exp_iss_q.pop_front());
    tick();
    rst = 1'b0;
    tick();
    load_cpb(16'd8);

    // Short glitch on the line is not a start bit
    rx_i = 1'b0;
    repeat (2) tick();
    rx_i = 1'b1;
    repeat (30) tick();
    check("glitch_err", 64'(err_o), 64'(0));
    check("glitch_busy", 64'(busy_o), 64'(0));

    // Full frame after reset
    exp_iss_q.push_back({8'h05, 16'h3C00, 16'h4000});
    send_frame(8'h05, 16'h3C00, 16'h4000);
    fpu_accept(2);
    exp_res_q.push_back({16'h4500, 5'h04});
    fpu_respond(16'h4500, 5'h04);
    wait_idle("t5_idle");

`ifdef FPU_UART_TX_EN
    // Result transmission; a divisor load during TX must not take effect
    exp_iss_q.push_back({8'h06, 16'h3C00, 16'h4000});
    send_frame(8'h06, 16'h3C00, 16'h4000);
    fpu_accept(0);
    exp_res_q.push_back({16'h4200, 5'h01});
    fpu_respond(16'h4200, 5'h01);
    fork
      begin
        uart_rx_byte(8'h00, "tx_b0");
        uart_rx_byte(8'h42, "tx_b1");
        uart_rx_byte(8'h01, "tx_flags");
        check("tx_busy_stop", 64'(busy_o), 64'(1));
      end
      begin
        repeat (30) tick();
        load_cpb(16'd16);
      end
    join
    wait_idle("t6_idle");
`else
    check("tx_tied_high", 64'(tx_o), 64'(1));
`endif

    repeat (5) tick();
    check("iss_q_empty", 64'(exp_iss_q.size()), 64'(0));
    check("res_q_empty", 64'(exp_res_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_uart_cmd_bridge.md
Name: fpu_uart_cmd_bridge

Overview:
Parametrised UART command front-end for the FPU in the Caravel user project. It replaces the fixed 16-bit, receive-only serial path. It receives byte frames on a UART line at a runtime-programmable baud divisor, assembles an opcode and operands of width FLEN, and issues one operation to the FPU core through a valid/ready handshake. It then captures the result and flags, and can optionally transmit them back over UART.

Parameters:
FLEN, 16, operand/result width in bits; must be 16 or 32 (multiple of 8).
CPB_W, 16, width of the clocks-per-bit divisor.
DEFAULT_CPB, 348, divisor used from reset until cpb_i is loaded.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
rx_i  input  1  UART receive line (idle high)
cpb_i  input  CPB_W  clocks-per-bit value
cpb_load_i  input  1  load cpb_i into the divisor register
fpu_valid_o  output  1  operation request to FPU
fpu_ready_i  input  1  FPU accepts request
fpu_op_o  output  8  opcode byte
fpu_a_o  output  FLEN  operand A
fpu_b_o  output  FLEN  operand B (0 for unary ops)
fpu_res_valid_i  input  1  FPU result strobe
fpu_res_i  input  FLEN  FPU result
fpu_flags_i  input  5  IEEE flags (NV,DZ,OF,UF,NX)
result_o  output  FLEN  last captured result
flags_o  output  5  last captured flags
result_valid_o  output  1  one-cycle pulse on capture
busy_o  output  1  high in any state other than IDLE
err_o  output  2  sticky errors: [0] framing, [1] overrun
tx_o  output  1  UART transmit line

Behaviour:
- Reset (async, rst=1): FSM=IDLE. All outputs 0 except tx_o=1. Divisor=DEFAULT_CPB. err_o cleared. Byte counters=0.
- Divisor: cpb_load_i loads cpb_i only while the receiver and transmitter are idle; a load at any other time is ignored. Values below 4 are stored as 4.
- RX:
  - rx_i passes through a 2-flop synchroniser.
  - A falling edge starts reception; the start bit is re-checked at CPB/2 (floor). If it is high, the edge is treated as a glitch: return to idle with no error.
  - 8 data bits are sampled LSB first, one every CPB cycles from the mid-start sample.
  - Stop bit: if low, set err_o[0], discard the byte, and abort any partial frame (FSM to IDLE).
  - A good byte produces a 1-cycle internal byte strobe.
- Frame format: opcode byte, then operand A as FLEN/8 bytes LSB first, then operand B as FLEN/8 bytes LSB first. If opcode[7]=1 the op is unary: operand B is omitted and fpu_b_o=0.
- FSM:
  - IDLE: a byte strobe latches fpu_op_o and moves to OPA.
  - OPA: shift bytes into A. After FLEN/8 bytes go to ISSUE if unary, else to OPB.
  - OPB: collect FLEN/8 bytes into B, then go to ISSUE.
  - ISSUE: fpu_valid_o=1, with op/a/b held stable, until the cycle fpu_ready_i=1, then go to WAIT.
  - WAIT: on fpu_res_valid_i, capture result_o and flags_o, pulse result_valid_o, then go to TX (feature enabled) or IDLE.
  - TX: see Optional Feature. Returns to IDLE after the last stop bit.
- A byte strobe in ISSUE, WAIT or TX is dropped and sets err_o[1].
- fpu_res_valid_i outside WAIT is ignored.
- Latency: fpu_valid_o rises the cycle after the last operand byte strobe. result_valid_o rises the cycle after fpu_res_valid_i.
- err_o clears only on reset.
- Reset mid-frame or mid-operation: immediate return to IDLE. Partial bytes are discarded and tx_o=1.

Optional Feature:
Macro: FPU_UART_TX_EN.
- Defined: after capture, transmit the result as FLEN/8 bytes LSB first, then one byte {3'b000, flags}. Format is 8N1 using the same divisor. busy_o stays high until the final stop bit ends.
- Undefined: no TX logic, no TX state; tx_o is tied to 1 and WAIT goes directly to IDLE.

Test Plan:
1. CPB=8, FLEN=16. Send bytes 01,00,3C,00,40 -> one fpu_valid_o with op=01, a=3C00, b=4000. Hold fpu_ready_i=0 for 3 cycles -> fpu_valid_o and operands stay stable. Return res=4200, flags=00 -> result_o=4200, result_valid_o pulses for exactly 1 cycle.
2. Unary: send 85,00,3C -> issue after the 3rd byte with b=0000. FSM returns to IDLE after the result.
3. Send 01,00 then a byte with its stop bit low -> err_o=01, FSM=IDLE, no issue. The following full good frame issues correctly.
4. Send a byte while in WAIT -> err_o[1]=1, the byte is dropped, and the operation completes unaffected.
5. Assert rst during OPA and during ISSUE -> outputs reach reset values asynchronously. The next full frame works.
6. With FPU_UART_TX_EN defined, result 4200 with flags=01 -> tx_o carries bytes 00,42,01 at CPB=8. A cpb_load_i during TX is ignored.
